// File: rtl/switch_port_tx.sv
// Switch egress port transmitter: pops a frame descriptor, streams len
// bytes from the data FIFO to the port, then enforces the inter-frame gap.
module switch_port_tx #(
   parameter int IFG   = 12,
   parameter int LEN_W = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ptr_fifo_empty,
   output logic        ptr_fifo_rd,
   input  logic [15:0] ptr_fifo_dout,
   output logic        data_fifo_rd,
   input  logic [7:0]  data_fifo_dout,
   input  logic        pause,
   output logic        tx_dv,
   output logic        tx_sof,
   output logic        tx_eof,
   output logic [7:0]  tx_dout,
   output logic        busy,
   output logic [15:0] frame_cnt,
   output logic [7:0]  zlen_cnt
);

   localparam int GW = (IFG > 1) ? $clog2(IFG) : 1;

   typedef enum logic [2:0] {
      IDLE,
      PTR_RD,
      PTR_CAP,
      XMIT,
      GAP
   } state_t;

   state_t state, state_d;

   logic [LEN_W-1:0] len_in;
   logic [LEN_W-1:0] cnt, cnt_d;
   logic [GW-1:0]    gap, gap_d;
   logic             armed;
   logic             first_d, last_d;
   logic             zlen_inc;
   logic             rd_first, rd_last;
   logic             vld_q, sof_q, eof_q;
   logic             rsvd_unused;

   assign len_in      = ptr_fifo_dout[LEN_W-1:0];
   assign rsvd_unused = ^ptr_fifo_dout[15:LEN_W];

   // cnt holds the reads still owed after the current XMIT cycle
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      gap_d    = gap;
      first_d  = 1'b0;
      last_d   = 1'b0;
      zlen_inc = 1'b0;
      unique case (state)
         IDLE: begin
            if (armed && !ptr_fifo_empty && !pause)
               state_d = PTR_RD;
         end
         PTR_RD: state_d = PTR_CAP;
         PTR_CAP: begin
            if (len_in == '0) begin
               zlen_inc = 1'b1;
               state_d  = IDLE;
            end else begin
               state_d = XMIT;
               cnt_d   = len_in - LEN_W'(1);
               first_d = 1'b1;
               last_d  = (len_in == LEN_W'(1));
            end
         end
         XMIT: begin
            if (cnt == '0) begin
               state_d = GAP;
               gap_d   = GW'(IFG - 1);
            end else begin
               cnt_d  = cnt - LEN_W'(1);
               last_d = (cnt == LEN_W'(1));
            end
         end
         GAP: begin
            if (gap == '0)
               state_d = IDLE;
            else
               gap_d = gap - GW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   // armed holds off the first descriptor pop for one cycle after reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         gap          <= '0;
         armed        <= 1'b0;
         ptr_fifo_rd  <= 1'b0;
         data_fifo_rd <= 1'b0;
         busy         <= 1'b0;
         rd_first     <= 1'b0;
         rd_last      <= 1'b0;
         vld_q        <= 1'b0;
         sof_q        <= 1'b0;
         eof_q        <= 1'b0;
         tx_dv        <= 1'b0;
         tx_sof       <= 1'b0;
         tx_eof       <= 1'b0;
         tx_dout      <= '0;
         frame_cnt    <= '0;
         zlen_cnt     <= '0;
      end else begin
         state        <= state_d;
         cnt          <= cnt_d;
         gap          <= gap_d;
         armed        <= 1'b1;
         ptr_fifo_rd  <= (state_d == PTR_RD);
         data_fifo_rd <= (state_d == XMIT);
         busy         <= (state_d != IDLE);
         rd_first     <= first_d;
         rd_last      <= last_d;
         vld_q        <= data_fifo_rd;
         sof_q        <= rd_first;
         eof_q        <= rd_last;
         tx_dv        <= vld_q;
         tx_sof       <= sof_q;
         tx_eof       <= eof_q;
         tx_dout      <= vld_q ? data_fifo_dout : 8'h00;
         if (eof_q)
            frame_cnt <= frame_cnt + 16'd1;
         if (zlen_inc && zlen_cnt != 8'hFF)
            zlen_cnt <= zlen_cnt + 8'd1;
      end
   end

endmodule
